// File: rtl/mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_scheduler
//  Description : Round-robin, packet-aware scheduler sharing one W-bit 2:1 mux
//                tree among N valid/ready requesters, with a registered output.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_rr_scheduler #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req_valid,
   input  logic [N-1:0]         req_last,
   input  logic [N*W-1:0]       req_data,
   output logic [N-1:0]         req_ready,
   output logic                 out_valid,
   output logic                 out_last,
   output logic [W-1:0]         out_data,
   input  logic                 out_ready,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic                 locked
);

   localparam int c_IW     = $clog2(N);
   localparam int c_LEAVES = 1 << c_IW;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t            r_state;
   logic [c_IW-1:0]   r_ptr;
   logic [c_IW-1:0]   r_grant;
   logic              r_out_valid;
   logic              r_out_last;
   logic [W-1:0]      r_out_data;

   logic              w_can_load;
   logic              w_found;
   logic [c_IW-1:0]   w_winner;
   logic [c_IW-1:0]   w_idx;
   logic [c_IW-1:0]   w_sel;
   logic              w_take;
   logic [W-1:0]      w_mux;
   logic [W-1:0]      w_node [2*c_LEAVES-1];

   // Modulo-N increment with explicit wrap for non-power-of-two N.
   function automatic logic [c_IW-1:0] inc_mod(input logic [c_IW-1:0] v);
      if (v == c_IW'(N-1)) begin
         return '0;
      end
      return v + 1'b1;
   endfunction

   assign w_can_load = !r_out_valid || out_ready;

   // First valid requester scanning ptr, ptr+1, ... ptr-1 (mod N).
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_ptr;
      w_idx    = r_ptr;
      for (int k = 0; k < N; k++) begin
         if (!w_found && req_valid[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
         w_idx = inc_mod(w_idx);
      end
   end

   always_comb begin
      w_sel  = r_grant;
      w_take = 1'b0;
      if (r_state == ST_LOCKED) begin
         w_take = req_valid[r_grant] && w_can_load && rst_n;
      end else begin
         w_sel  = w_winner;
         w_take = w_found && w_can_load && rst_n;
      end
   end

   assign req_ready = w_take ? (N'(1) << w_sel) : '0;

   // Binary 2:1 mux tree in heap order; leaf j sits at node LEAVES-1+j and
   // the root selects on the MSB of the select.
   for (genvar j = 0; j < c_LEAVES; j++) begin : g_leaf
      if (j < N) begin : g_src
         assign w_node[c_LEAVES-1+j] = req_data[j*W +: W];
      end else begin : g_pad
         assign w_node[c_LEAVES-1+j] = '0;
      end
   end

   for (genvar i = 0; i < c_LEAVES-1; i++) begin : g_node
      localparam int c_DEPTH = $clog2(i+2) - 1;
      assign w_node[i] = w_sel[c_IW-1-c_DEPTH] ? w_node[2*i+2] : w_node[2*i+1];
   end

   assign w_mux = w_node[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_grant     <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (w_take) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux;
            r_out_last  <= req_last[w_sel];
            r_grant     <= w_sel;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_take) begin
                  if (req_last[w_sel]) begin
                     r_ptr <= inc_mod(w_sel);
                  end else begin
                     r_state <= ST_LOCKED;
                  end
               end
            end
            ST_LOCKED: begin
               if (w_take && req_last[r_grant]) begin
                  r_ptr   <= inc_mod(r_grant);
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign out_data  = r_out_data;
   assign grant_idx = r_grant;
   assign locked    = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_rr_scheduler
//  Description : Directed self-checking bench for mux_rr_scheduler (N=4, W=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux_rr_scheduler;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_last;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic        out_last;
   logic [7:0]  out_data;
   logic        out_ready;
   logic [1:0]  grant_idx;
   logic        locked;

   int n_err = 0;
   int n_chk = 0;

   mux_rr_scheduler #(.N(4), .W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_data  (out_data),
      .out_ready (out_ready),
      .grant_idx (grant_idx),
      .locked    (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic l,
                          input logic [7:0] d, input logic [1:0] g, input logic lk);
      chk({tag, ".valid"},  32'(out_valid), 32'(v));
      chk({tag, ".last"},   32'(out_last),  32'(l));
      chk({tag, ".data"},   32'(out_data),  32'(d));
      chk({tag, ".grant"},  32'(grant_idx), 32'(g));
      chk({tag, ".locked"}, 32'(locked),    32'(lk));
   endtask

   // Inputs change 1ns after a rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'hF;
      req_last  = 4'hF;
      req_data  = 32'h44332211;
      out_ready = 1'b1;
      #2;
      chk_out("reset", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
      chk("reset.ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Round robin over all four requesters.
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("rr%0d.ready", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
         tick();
         chk_out($sformatf("rr%0d", k), 1'b1, 1'b1, 8'(8'h11 * ((k % 4) + 1)), 2'(k % 4), 1'b0);
      end

      // Packet lock: req1 sends three beats while req2 waits (ptr=1 now).
      req_valid = 4'b0110;
      req_last  = 4'b0000;
      req_data[15:8] = 8'hA1;
      #1;
      chk("pkt1.ready", 32'(req_ready), 32'h2);
      tick();
      chk_out("pkt1", 1'b1, 1'b0, 8'hA1, 2'd1, 1'b1);

      req_valid = 4'b0100;
      #1;
      chk("pktgap.ready", 32'(req_ready), 32'h0);
      tick();
      chk("pktgap.valid", 32'(out_valid), 32'h0);
      chk("pktgap.locked", 32'(locked), 32'h1);

      req_valid = 4'b0110;
      req_data[15:8] = 8'hA2;
      #1;
      chk("pkt2.ready", 32'(req_ready), 32'h2);
      tick();
      chk_out("pkt2", 1'b1, 1'b0, 8'hA2, 2'd1, 1'b1);

      req_last  = 4'b0010;
      req_data[15:8] = 8'hA3;
      #1;
      chk("pkt3.ready", 32'(req_ready), 32'h2);
      tick();
      chk_out("pkt3", 1'b1, 1'b1, 8'hA3, 2'd1, 1'b0);

      req_valid = 4'b0100;
      req_last  = 4'hF;
      #1;
      chk("pkt4.ready", 32'(req_ready), 32'h4);
      tick();
      chk_out("pkt4", 1'b1, 1'b1, 8'h33, 2'd2, 1'b0);

      // Backpressure holds the output register (ptr=3).
      out_ready = 1'b0;
      req_valid = 4'b1000;
      #1;
      chk("bp.ready", 32'(req_ready), 32'h0);
      tick();
      chk_out("bp", 1'b1, 1'b1, 8'h33, 2'd2, 1'b0);

      out_ready = 1'b1;
      #1;
      chk("drain.ready", 32'(req_ready), 32'h8);
      tick();
      chk_out("drain", 1'b1, 1'b1, 8'h44, 2'd3, 1'b0);

      // Wrap/skip: reach ptr=3, then only req1 valid.
      req_valid = 4'b0100;
      #1;
      chk("wrapa.ready", 32'(req_ready), 32'h4);
      tick();
      chk("wrapa.grant", 32'(grant_idx), 32'h2);

      req_valid = 4'b0010;
      #1;
      chk("wrapb.ready", 32'(req_ready), 32'h2);
      tick();
      chk_out("wrapb", 1'b1, 1'b1, 8'hA3, 2'd1, 1'b0);

      req_valid = 4'hF;
      #1;
      chk("wrapc.ready", 32'(req_ready), 32'h4);
      tick();
      chk("wrapc.grant", 32'(grant_idx), 32'h2);

      req_valid = 4'h0;
      #1;
      chk("idle.ready", 32'(req_ready), 32'h0);
      tick();
      chk_out("idle", 1'b0, 1'b1, 8'h33, 2'd2, 1'b0);

      // Reset in the middle of a packet (ptr=3).
      req_valid = 4'b1000;
      req_last  = 4'b0000;
      #1;
      chk("rstpkt.ready", 32'(req_ready), 32'h8);
      tick();
      chk_out("rstpkt", 1'b1, 1'b0, 8'h44, 2'd3, 1'b1);

      #2;
      rst_n = 1'b0;
      #1;
      chk_out("midrst", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
      chk("midrst.ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      req_valid = 4'hF;
      req_last  = 4'hF;
      #1;
      chk("postrst.ready", 32'(req_ready), 32'h1);
      tick();
      chk_out("postrst", 1'b1, 1'b1, 8'h11, 2'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
